// File: rtl/render_dispatcher.sv
// Frame scheduler: clear fill, round-robin triangle dispatch, merged pixel output.
// Optional clear rectangle enabled by RENDER_DISPATCH_SCISSOR_EN.
module render_dispatcher #(
    parameter int WIDTH     = 320,
    parameter int HEIGHT    = 240,
    parameter int NUM_LANES = 2,
    parameter int TRI_W     = 144,
    parameter int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 begin_frame,
    input  logic [11:0]                          fill_color,
`ifdef RENDER_DISPATCH_SCISSOR_EN
    input  logic [15:0]                          clear_x0,
    input  logic [15:0]                          clear_y0,
    input  logic [15:0]                          clear_x1,
    input  logic [15:0]                          clear_y1,
`endif
    input  logic [TRI_W-1:0]                     tri_in,
    input  logic                                 tri_valid,
    output logic                                 tri_ready,
    output logic [NUM_LANES-1:0][TRI_W-1:0]      lane_tri,
    output logic [NUM_LANES-1:0]                 lane_tri_valid,
    input  logic [NUM_LANES-1:0]                 lane_tri_ready,
    input  logic [NUM_LANES-1:0]                 lane_busy,
    input  logic [NUM_LANES-1:0][15:0]           lane_px_x,
    input  logic [NUM_LANES-1:0][15:0]           lane_px_y,
    input  logic [NUM_LANES-1:0][31:0]           lane_px_depth,
    input  logic [NUM_LANES-1:0][11:0]           lane_px_color,
    input  logic [NUM_LANES-1:0]                 lane_px_valid,
    output logic [NUM_LANES-1:0]                 lane_px_ready,
    output logic [15:0]                          out_pixel_x,
    output logic [15:0]                          out_pixel_y,
    output logic [31:0]                          out_depth,
    output logic [11:0]                          out_color,
    output logic                                 out_compare_depth,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 busy,
    output logic                                 frame_overrun
);

    typedef enum logic [1:0] {IDLE, FILL, DRAW, DRAIN} state_t;

    localparam logic [15:0] XMAX = 16'(WIDTH - 1);
    localparam logic [15:0] YMAX = 16'(HEIGHT - 1);
    localparam logic [31:0] FAR_DEPTH = 32'h7FFF_FFFF;

    // First requester at or after ptr, wrapping around the lanes.
    function automatic logic [LANE_W-1:0] rr_pick(
        input logic [NUM_LANES-1:0] req,
        input logic [LANE_W-1:0]    ptr
    );
        logic [LANE_W-1:0] pick;
        int idx;
        pick = ptr;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_LANES;
            if (req[idx]) pick = LANE_W'(idx);
        end
        return pick;
    endfunction

    function automatic logic [LANE_W-1:0] rr_next(input logic [LANE_W-1:0] sel);
        return LANE_W'((int'(sel) + 1) % NUM_LANES);
    endfunction

    function automatic logic [NUM_LANES-1:0] onehot(input logic [LANE_W-1:0] sel);
        logic [NUM_LANES-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (int'(sel) == i) v[i] = 1'b1;
        end
        return v;
    endfunction

    state_t            state_q;
    logic              busy_q;
    logic              ovr_q;
    logic [11:0]       fcol_q;
    logic [15:0]       fx_q;
    logic [15:0]       fy_q;
    logic [15:0]       xs_q;
    logic [15:0]       xe_q;
    logic [15:0]       ye_q;
    logic              fdone_q;
    logic              ov_q;
    logic [15:0]       ox_q;
    logic [15:0]       oy_q;
    logic [31:0]       od_q;
    logic [11:0]       oc_q;
    logic              ocmp_q;
    logic [LANE_W-1:0] rr_tri_q;
    logic [LANE_W-1:0] rr_px_q;

    logic [15:0]       bx0;
    logic [15:0]       bx1;
    logic [15:0]       by0;
    logic [15:0]       by1;
    logic              bempty;

    always_comb begin
`ifdef RENDER_DISPATCH_SCISSOR_EN
        bx0    = clear_x0;
        by0    = clear_y0;
        bx1    = (clear_x1 > XMAX) ? XMAX : clear_x1;
        by1    = (clear_y1 > YMAX) ? YMAX : clear_y1;
        bempty = (clear_x1 < clear_x0) || (clear_y1 < clear_y0) ||
                 (clear_x0 > XMAX) || (clear_y0 > YMAX);
`else
        bx0    = 16'd0;
        by0    = 16'd0;
        bx1    = XMAX;
        by1    = YMAX;
        bempty = 1'b0;
`endif
    end

    logic [LANE_W-1:0] tri_sel;
    logic [LANE_W-1:0] px_sel;
    logic              can_load;
    logic              px_go;
    logic              drain_done;
    logic              start;
    logic              fill_last;
    logic              first_last;

    always_comb begin
        tri_sel        = rr_pick(lane_tri_ready, rr_tri_q);
        px_sel         = rr_pick(lane_px_valid, rr_px_q);
        tri_ready      = (state_q == DRAW) && (|lane_tri_ready);
        lane_tri_valid = (tri_valid && tri_ready) ? onehot(tri_sel) : '0;
        can_load       = !ov_q || out_ready;
        px_go          = ((state_q == DRAW) || (state_q == DRAIN)) &&
                         (|lane_px_valid) && can_load;
        lane_px_ready  = px_go ? onehot(px_sel) : '0;
        drain_done     = (state_q == DRAIN) && (lane_busy == '0) &&
                         (lane_px_valid == '0) && !ov_q;
        start          = ((state_q == IDLE) && begin_frame) || drain_done;
        fill_last      = (fx_q == xe_q) && (fy_q == ye_q);
        first_last     = (bx0 == bx1) && (by0 == by1);
    end

    assign lane_tri          = {NUM_LANES{tri_in}};
    assign out_pixel_x       = ox_q;
    assign out_pixel_y       = oy_q;
    assign out_depth         = od_q;
    assign out_color         = oc_q;
    assign out_compare_depth = ocmp_q;
    assign out_valid         = ov_q;
    assign busy              = busy_q;
    assign frame_overrun     = ovr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            ovr_q    <= 1'b0;
            fcol_q   <= '0;
            fx_q     <= '0;
            fy_q     <= '0;
            xs_q     <= '0;
            xe_q     <= '0;
            ye_q     <= '0;
            fdone_q  <= 1'b0;
            ov_q     <= 1'b0;
            ox_q     <= '0;
            oy_q     <= '0;
            od_q     <= '0;
            oc_q     <= '0;
            ocmp_q   <= 1'b0;
            rr_tri_q <= '0;
            rr_px_q  <= '0;
        end else begin
            ovr_q <= 1'b0;
            if (ov_q && out_ready) ov_q <= 1'b0;

            unique case (state_q)
                IDLE: ;
                FILL: begin
                    if (begin_frame) ovr_q <= 1'b1;
                    if (can_load) begin
                        if (fdone_q) begin
                            state_q <= DRAW;
                        end else begin
                            ov_q   <= 1'b1;
                            ox_q   <= fx_q;
                            oy_q   <= fy_q;
                            od_q   <= FAR_DEPTH;
                            oc_q   <= fcol_q;
                            ocmp_q <= 1'b0;
                            if (fill_last) begin
                                fdone_q <= 1'b1;
                            end else if (fx_q == xe_q) begin
                                fx_q <= xs_q;
                                fy_q <= fy_q + 16'd1;
                            end else begin
                                fx_q <= fx_q + 16'd1;
                            end
                        end
                    end
                end
                DRAW: begin
                    if (begin_frame) state_q <= DRAIN;
                    if (tri_valid && tri_ready) rr_tri_q <= rr_next(tri_sel);
                end
                DRAIN: begin
                    if (begin_frame) ovr_q <= 1'b1;
                end
            endcase

            if (px_go) begin
                ov_q    <= 1'b1;
                ox_q    <= lane_px_x[px_sel];
                oy_q    <= lane_px_y[px_sel];
                od_q    <= lane_px_depth[px_sel];
                oc_q    <= lane_px_color[px_sel];
                ocmp_q  <= 1'b1;
                rr_px_q <= rr_next(px_sel);
            end

            // The first fill pixel goes straight into the output register.
            if (start) begin
                state_q <= FILL;
                busy_q  <= 1'b1;
                fcol_q  <= fill_color;
                xs_q    <= bx0;
                xe_q    <= bx1;
                ye_q    <= by1;
                fdone_q <= bempty || first_last;
                if (bx0 == bx1) begin
                    fx_q <= bx0;
                    fy_q <= by0 + 16'd1;
                end else begin
                    fx_q <= bx0 + 16'd1;
                    fy_q <= by0;
                end
                if (!bempty) begin
                    ov_q   <= 1'b1;
                    ox_q   <= bx0;
                    oy_q   <= by0;
                    od_q   <= FAR_DEPTH;
                    oc_q   <= fill_color;
                    ocmp_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_render_dispatcher.sv
// Bench for render_dispatcher: fill table, directed dispatch/drain, random merge model.
module tb_render_dispatcher;

    logic              clk = 1'b0;
    logic              rst;
    logic              begin_frame;
    logic [11:0]       fill_color;
    logic [15:0]       clear_x0, clear_y0, clear_x1, clear_y1;
    logic [15:0]       tri_in;
    logic              tri_valid;
    logic              tri_ready;
    logic [1:0][15:0]  lane_tri;
    logic [1:0]        lane_tri_valid;
    logic [1:0]        lane_tri_ready;
    logic [1:0]        lane_busy;
    logic [1:0][15:0]  lane_px_x, lane_px_y;
    logic [1:0][31:0]  lane_px_depth;
    logic [1:0][11:0]  lane_px_color;
    logic [1:0]        lane_px_valid;
    logic [1:0]        lane_px_ready;
    logic [15:0]       out_pixel_x, out_pixel_y;
    logic [31:0]       out_depth;
    logic [11:0]       out_color;
    logic              out_compare_depth;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              frame_overrun;

    always #5 clk = ~clk;

    render_dispatcher #(
        .WIDTH(4), .HEIGHT(2), .NUM_LANES(2), .TRI_W(16)
    ) dut (
        .clk(clk), .rst(rst), .begin_frame(begin_frame), .fill_color(fill_color),
`ifdef RENDER_DISPATCH_SCISSOR_EN
        .clear_x0(clear_x0), .clear_y0(clear_y0),
        .clear_x1(clear_x1), .clear_y1(clear_y1),
`endif
        .tri_in(tri_in), .tri_valid(tri_valid), .tri_ready(tri_ready),
        .lane_tri(lane_tri), .lane_tri_valid(lane_tri_valid),
        .lane_tri_ready(lane_tri_ready), .lane_busy(lane_busy),
        .lane_px_x(lane_px_x), .lane_px_y(lane_px_y),
        .lane_px_depth(lane_px_depth), .lane_px_color(lane_px_color),
        .lane_px_valid(lane_px_valid), .lane_px_ready(lane_px_ready),
        .out_pixel_x(out_pixel_x), .out_pixel_y(out_pixel_y),
        .out_depth(out_depth), .out_color(out_color),
        .out_compare_depth(out_compare_depth), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .frame_overrun(frame_overrun)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        bf;
        logic        rdy;
        logic        v;
        logic [15:0] x;
        logic [15:0] y;
        logic        ovr;
    } fvec_t;

    fvec_t fv[10];

    function automatic int pick(input logic [1:0] req, input int ptr);
        for (int k = 0; k < 2; k++) begin
            if (req[(ptr + k) % 2]) return (ptr + k) % 2;
        end
        return 0;
    endfunction

    // Reference model state for the merge / dispatch phase
    int          m_rr_tri, m_rr_px;
    bit          m_ov;
    logic [15:0] m_x, m_y;
    logic [31:0] m_d;
    logic [11:0] m_c;
    int          seq[2];
    logic [1:0]  pv;

    task automatic drive_lane_px();
        for (int i = 0; i < 2; i++) begin
            lane_px_x[i]     = 16'(i * 256 + seq[i] % 256);
            lane_px_y[i]     = 16'(seq[i]);
            lane_px_depth[i] = 32'((i << 16) | seq[i]);
            lane_px_color[i] = 12'(seq[i] * 3 + i);
        end
        lane_px_valid = pv;
    endtask

    initial begin
        logic [1:0] exp_l[4];
        logic [15:0] sx[4];
        logic [15:0] sy[4];
        int got;

        fv[0] = '{1'b0, 1'b1, 1'b1, 16'd0, 16'd0, 1'b0};
        fv[1] = '{1'b0, 1'b1, 1'b1, 16'd1, 16'd0, 1'b0};
        fv[2] = '{1'b0, 1'b0, 1'b1, 16'd2, 16'd0, 1'b0};
        fv[3] = '{1'b0, 1'b1, 1'b1, 16'd2, 16'd0, 1'b0};
        fv[4] = '{1'b1, 1'b1, 1'b1, 16'd3, 16'd0, 1'b0};
        fv[5] = '{1'b0, 1'b1, 1'b1, 16'd0, 16'd1, 1'b1};
        fv[6] = '{1'b0, 1'b1, 1'b1, 16'd1, 16'd1, 1'b0};
        fv[7] = '{1'b0, 1'b1, 1'b1, 16'd2, 16'd1, 1'b0};
        fv[8] = '{1'b0, 1'b1, 1'b1, 16'd3, 16'd1, 1'b0};
        fv[9] = '{1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0};
        exp_l = '{2'b01, 2'b10, 2'b01, 2'b10};

        rst = 1'b1;
        begin_frame = 1'b0;
        fill_color = 12'h000;
        clear_x0 = 16'd0; clear_y0 = 16'd0;
        clear_x1 = 16'hFFFF; clear_y1 = 16'hFFFF;
        tri_in = 16'h0;
        tri_valid = 1'b1;
        lane_tri_ready = 2'b11;
        lane_busy = 2'b00;
        seq[0] = 0; seq[1] = 0;
        pv = 2'b11;
        drive_lane_px();
        out_ready = 1'b1;

        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_tri_ready", tri_ready, 0);
        chk("rst_lane_tri_valid", lane_tri_valid, 0);
        chk("rst_lane_px_ready", lane_px_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", frame_overrun, 0);
        chk("rst_out_x", out_pixel_x, 0);
        chk("rst_out_depth", out_depth, 0);
        rst = 1'b0;
        tick();
        #1;
        chk("idle_px_ready", lane_px_ready, 0);
        chk("idle_tri_ready", tri_ready, 0);
        chk("idle_busy", busy, 0);
        pv = 2'b00;
        drive_lane_px();
        tri_valid = 1'b0;

        // Full-screen fill with a stall and an ignored begin_frame
        begin_frame = 1'b1;
        fill_color = 12'hABC;
        tick();
        fill_color = 12'h000;
        for (int k = 0; k < 10; k++) begin
            begin_frame = fv[k].bf;
            out_ready = fv[k].rdy;
            #1;
            chk($sformatf("fill%0d_valid", k), out_valid, fv[k].v);
            chk($sformatf("fill%0d_overrun", k), frame_overrun, fv[k].ovr);
            if (fv[k].v) begin
                chk($sformatf("fill%0d_x", k), out_pixel_x, fv[k].x);
                chk($sformatf("fill%0d_y", k), out_pixel_y, fv[k].y);
                chk($sformatf("fill%0d_depth", k), out_depth, 32'h7FFF_FFFF);
                chk($sformatf("fill%0d_color", k), out_color, 12'hABC);
                chk($sformatf("fill%0d_cmp", k), out_compare_depth, 0);
            end
            if (k == 0) begin
                chk("fill_tri_ready", tri_ready, 0);
                chk("fill_busy", busy, 1);
            end
            if (k == 9) chk("draw_tri_ready", tri_ready, 1);
            tick();
        end
        begin_frame = 1'b0;

        // Back-to-back triangles, both lanes ready
        for (int k = 0; k < 4; k++) begin
            tri_valid = 1'b1;
            tri_in = 16'(16'h100 + k);
            lane_tri_ready = 2'b11;
            #1;
            chk($sformatf("rr_tri%0d", k), lane_tri_valid, exp_l[k]);
            chk($sformatf("lane_tri%0d", k), lane_tri[1], 16'h100 + k);
            tick();
        end
        lane_tri_ready = 2'b10;
        #1;
        chk("skip_lane0", lane_tri_valid, 2'b10);
        chk("skip_tri_ready", tri_ready, 1);
        tick();
        lane_tri_ready = 2'b00;
        #1;
        chk("none_ready", tri_ready, 0);
        chk("none_ready_valid", lane_tri_valid, 0);
        tick();

        // Randomised dispatch and merge against the model
        m_rr_tri = 0; m_rr_px = 0; m_ov = 1'b0;
        m_x = '0; m_y = '0; m_d = '0; m_c = '0;
        for (int c = 0; c < 400; c++) begin
            logic [1:0] exp_ltv, exp_lpr;
            int t_sel, p_sel;
            bit can;
            tri_valid = 1'($urandom % 2);
            lane_tri_ready = 2'($urandom % 4);
            tri_in = 16'($urandom);
            lane_busy = 2'($urandom % 4);
            if (c >= 396) begin
                pv = 2'b00;
                out_ready = 1'b1;
            end else if (c >= 200 && c < 260) begin
                pv = 2'b11;
                out_ready = 1'(c % 2);
            end else begin
                for (int i = 0; i < 2; i++) if (!pv[i]) pv[i] = 1'($urandom % 2);
                out_ready = 1'($urandom % 3 != 0);
            end
            drive_lane_px();
            #1;
            t_sel = pick(lane_tri_ready, m_rr_tri);
            exp_ltv = (tri_valid && lane_tri_ready != 0) ? 2'(1 << t_sel) : 2'b00;
            can = !m_ov || out_ready;
            p_sel = pick(pv, m_rr_px);
            exp_lpr = (can && pv != 0) ? 2'(1 << p_sel) : 2'b00;
            chk("m_tri_ready", tri_ready, lane_tri_ready != 0);
            chk("m_lane_tri_valid", lane_tri_valid, exp_ltv);
            chk("m_lane_tri0", lane_tri[0], tri_in);
            chk("m_lane_px_ready", lane_px_ready, exp_lpr);
            chk("m_out_valid", out_valid, m_ov);
            if (m_ov) begin
                chk("m_out_xy", {out_pixel_x, out_pixel_y}, {m_x, m_y});
                chk("m_out_depth", out_depth, m_d);
                chk("m_out_color", out_color, m_c);
                chk("m_out_cmp", out_compare_depth, 1);
            end
            if (exp_ltv != 0) m_rr_tri = (t_sel + 1) % 2;
            if (can) begin
                if (pv != 0) begin
                    m_ov = 1'b1;
                    m_x = lane_px_x[p_sel];
                    m_y = lane_px_y[p_sel];
                    m_d = lane_px_depth[p_sel];
                    m_c = lane_px_color[p_sel];
                    m_rr_px = (p_sel + 1) % 2;
                    seq[p_sel]++;
                    pv[p_sel] = 1'b0;
                end else begin
                    m_ov = 1'b0;
                end
            end
            tick();
        end

        // Drain: begin_frame while lane 1 is still busy
        tri_valid = 1'b0;
        lane_busy = 2'b10;
        lane_tri_ready = 2'b11;
        pv = 2'b00;
        drive_lane_px();
        out_ready = 1'b1;
        begin_frame = 1'b1;
        tick();
        begin_frame = 1'b0;
        fill_color = 12'h5A5;
        tri_valid = 1'b1;
        lane_px_x[1] = 16'h55; lane_px_y[1] = 16'h66;
        lane_px_depth[1] = 32'h1234; lane_px_color[1] = 12'h321;
        lane_px_valid = 2'b10;
        out_ready = 1'b0;
        #1;
        chk("drain_tri_ready", tri_ready, 0);
        chk("drain_lane_tri_valid", lane_tri_valid, 0);
        chk("drain_px_ready", lane_px_ready, 2'b10);
        tick();
        lane_px_valid = 2'b00;
        begin_frame = 1'b1;
        #1;
        chk("drain_out_valid", out_valid, 1);
        chk("drain_out_xy", {out_pixel_x, out_pixel_y}, {16'h55, 16'h66});
        chk("drain_out_cmp", out_compare_depth, 1);
        chk("drain_out_depth", out_depth, 32'h1234);
        tick();
        begin_frame = 1'b0;
        lane_busy = 2'b00;
        #1;
        chk("drain_overrun", frame_overrun, 1);
        chk("drain_stall_valid", out_valid, 1);
        chk("drain_stall_x", out_pixel_x, 16'h55);
        tick();
        out_ready = 1'b1;
        #1;
        chk("drain_hold_valid", out_valid, 1);
        chk("drain_no_fill_color", out_color, 12'h321);
        tick();
        #1;
        chk("drain_empty", out_valid, 0);
        chk("drain_busy", busy, 1);
        tick();
        fill_color = 12'h000;
        #1;
        chk("refill_valid", out_valid, 1);
        chk("refill_xy", {out_pixel_x, out_pixel_y}, 32'h0);
        chk("refill_cmp", out_compare_depth, 0);
        chk("refill_color", out_color, 12'h5A5);

        // Reset mid-fill
        rst = 1'b1;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_tri_ready", tri_ready, 0);
        rst = 1'b0;
        tick();

`ifdef RENDER_DISPATCH_SCISSOR_EN
        sx = '{16'd1, 16'd2, 16'd1, 16'd2};
        sy = '{16'd0, 16'd0, 16'd1, 16'd1};
        clear_x0 = 16'd1; clear_y0 = 16'd0;
        clear_x1 = 16'd2; clear_y1 = 16'd1;
        tri_valid = 1'b0;
        begin_frame = 1'b1;
        tick();
        begin_frame = 1'b0;
        got = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (out_valid) begin
                if (got < 4) chk($sformatf("sc_xy%0d", got),
                                 {out_pixel_x, out_pixel_y}, {sx[got], sy[got]});
                got++;
            end
            tick();
        end
        chk("sc_count", got, 4);
        #1;
        chk("sc_draw", tri_ready, 1);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        tick();
        clear_x0 = 16'd3; clear_x1 = 16'd1;
        begin_frame = 1'b1;
        tick();
        begin_frame = 1'b0;
        #1;
        chk("sc_empty_valid", out_valid, 0);
        tick();
        #1;
        chk("sc_empty_draw", tri_ready, 1);
`else
        sx = '{16'd0, 16'd0, 16'd0, 16'd0};
        sy = sx;
        got = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
